// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and helpers for the 1-D max-pool stage
package pool_pkg;

   // ACCUM gathers a window, OUTPUT presents its maximum downstream
   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } pool_state_t;

   // Sample width shared with the upstream convolution layer
   localparam int unsigned POOL_T = 16;

   typedef logic signed [POOL_T-1:0] sample_t;

   // Number of pooled results per input vector (last window may be partial)
   function automatic int unsigned pool_out_len(input int unsigned l, input int unsigned p);
      return (l + p - 1) / p;
   endfunction

endpackage

// File: rtl/maxpool_1d_stream_cmp.sv
// rtl/maxpool_1d_stream_cmp.sv - signed running-max with first-sample bypass
module maxpool_1d_stream_cmp #(
   parameter int T = 16
) (
   input  logic signed [T-1:0] cur_max,
   input  logic signed [T-1:0] sample,
   input  logic                first,
   output logic signed [T-1:0] result
);

   // First sample of a window seeds the max; later samples keep the larger value
   always_comb begin
      result = cur_max;
      if (first || (sample > cur_max)) begin
         result = sample;
      end
   end

endmodule

// File: rtl/maxpool_1d_stream.sv
// rtl/maxpool_1d_stream.sv - streaming non-overlapping 1-D max-pool stage
module maxpool_1d_stream
   import pool_pkg::*;
#(
   parameter int L = 57,
   parameter int P = 2,
   parameter int T = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [T-1:0] x_data,
   input  logic                x_valid,
   output logic                x_ready,
   output logic signed [T-1:0] y_data,
   output logic                y_valid,
   input  logic                y_ready,
   output logic                y_last
);

   localparam int WW = (P > 0) ? $clog2(P + 1) : 1;
   localparam int EW = (L > 1) ? $clog2(L) : 1;
   localparam logic [WW-1:0] WIN_LAST  = WW'(P - 1);
   localparam logic [EW-1:0] ELEM_LAST = EW'(L - 1);

   pool_state_t         state;
   logic [WW-1:0]       win_cnt;
   logic [EW-1:0]       elem_cnt;
   logic signed [T-1:0] max_reg;
   logic                last_reg;
   logic signed [T-1:0] next_max;
   logic                x_acc;
   logic                closes;
   logic                vec_end;

   // Ready passes straight through from downstream while a result is pending,
   // so a result can retire and a new sample enter in the same cycle
   assign x_ready = !reset && ((state == ACCUM) || y_ready);
   assign x_acc   = x_valid && x_ready;
   assign vec_end = (elem_cnt == ELEM_LAST);
   assign closes  = (win_cnt == WIN_LAST) || vec_end;

   assign y_valid = (state == OUTPUT);
   assign y_data  = max_reg;
   assign y_last  = last_reg;

   maxpool_1d_stream_cmp #(.T(T)) u_cmp (
      .cur_max (max_reg),
      .sample  (x_data),
      .first   (win_cnt == '0),
      .result  (next_max)
   );

   // Window/element counters, running max and the ACCUM/OUTPUT sequencing
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ACCUM;
         win_cnt  <= '0;
         elem_cnt <= '0;
         max_reg  <= '0;
         last_reg <= 1'b0;
      end else begin
         if ((state == OUTPUT) && y_ready) begin
            state    <= ACCUM;
            last_reg <= 1'b0;
         end
         if (x_acc) begin
            max_reg  <= next_max;
            elem_cnt <= vec_end ? '0 : elem_cnt + EW'(1);
            if (closes) begin
               win_cnt  <= '0;
               state    <= OUTPUT;
               last_reg <= vec_end;
            end else begin
               win_cnt  <= win_cnt + WW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// tb/tb_maxpool_1d_stream.sv - self-checking bench for maxpool_1d_stream
module tb_maxpool_1d_stream;
   import pool_pkg::*;

   localparam int L = 57;
   localparam int P = 2;

   logic    clk = 1'b0;
   logic    reset;
   sample_t x_data;
   logic    x_valid;
   logic    x_ready;
   sample_t y_data;
   logic    y_valid;
   logic    y_ready;
   logic    y_last;

   sample_t x1_data;
   logic    x1_valid;
   logic    x1_ready;
   sample_t y1_data;
   logic    y1_valid;
   logic    y1_ready;
   logic    y1_last;

   int nvec = 0;
   int nerr = 0;
   int yr_mode = 0;      // 0: ready high, 1: random, 2: ready low
   bit t1_active = 1'b0; // x_ready must stay high throughout the ramp

   sample_t got_d[$];
   bit      got_l[$];

   always #5 clk = ~clk;

   maxpool_1d_stream #(.L(L), .P(P), .T(16)) dut (
      .clk(clk), .reset(reset),
      .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
      .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_last(y_last)
   );

   maxpool_1d_stream #(.L(4), .P(1), .T(16)) dut1 (
      .clk(clk), .reset(reset),
      .x_data(x1_data), .x_valid(x1_valid), .x_ready(x1_ready),
      .y_data(y1_data), .y_valid(y1_valid), .y_ready(y1_ready), .y_last(y1_last)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Downstream ready pattern, updated just after each rising edge
   initial begin
      y_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (yr_mode)
            0:       y_ready = 1'b1;
            1:       y_ready = ($urandom_range(0, 3) != 0);
            default: y_ready = 1'b0;
         endcase
      end
   end

   // Reference model: collect each window's samples, emit the max when the
   // window is full or the vector ends; compare every output accept against it
   sample_t win_q[$];
   int      m_idx = 0;
   sample_t exp_d[$];
   bit      exp_l[$];
   bit      prev_hold = 1'b0;
   sample_t prev_d;
   bit      prev_l;

   always @(negedge clk) begin
      sample_t mx;
      if (reset) begin
         chk("x_ready_in_reset", x_ready, 0);
         win_q.delete();
         exp_d.delete();
         exp_l.delete();
         m_idx     = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", y_valid, 1);
            chk("hold_data", y_data, prev_d);
            chk("hold_last", y_last, prev_l);
         end
         if (t1_active) chk("ramp_x_ready", x_ready, 1);
         if (y_valid && y_ready) begin
            got_d.push_back(y_data);
            got_l.push_back(y_last);
            if (exp_d.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               chk("model_data", y_data, exp_d.pop_front());
               chk("model_last", y_last, exp_l.pop_front());
            end
         end
         if (x_valid && x_ready) begin
            win_q.push_back(x_data);
            if ((win_q.size() == P) || (m_idx == L - 1)) begin
               mx = win_q[0];
               foreach (win_q[k]) if (win_q[k] > mx) mx = win_q[k];
               exp_d.push_back(mx);
               exp_l.push_back(m_idx == L - 1);
               win_q.delete();
            end
            m_idx = (m_idx == L - 1) ? 0 : m_idx + 1;
         end
         prev_hold = y_valid && !y_ready;
         prev_d    = y_data;
         prev_l    = y_last;
      end
   end

   task automatic push(input sample_t v, input bit gaps);
      int c;
      bit acc;
      if (gaps) begin
         x_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      x_data  = v;
      x_valid = 1'b1;
      c   = 0;
      acc = 1'b0;
      while (!acc && c < 1000) begin
         @(negedge clk);
         acc = x_ready;
         @(posedge clk);
         #1;
         c++;
      end
      if (!acc) chk("push_timeout", 0, 1);
      x_valid = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int c = 0;
      while (got_d.size() < n && c < 3000) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk("output_count", got_d.size(), n);
   endtask

   initial begin
      int b;
      int c;
      sample_t hd;
      bit hl;
      sample_t v1[8];
      bit seen900;

      reset    = 1'b1;
      x_valid  = 1'b0;
      x_data   = '0;
      x1_valid = 1'b0;
      x1_data  = '0;
      y1_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_y_valid", y_valid, 0);
      chk("reset_y_last", y_last, 0);
      chk("reset_y_data", y_data, 0);
      chk("reset_x_ready", x_ready, 1);
      @(posedge clk);
      #1;

      // 1: ramp 0..56, continuous flow
      b = got_d.size();
      t1_active = 1'b1;
      for (int i = 0; i < L; i++) push(sample_t'(i), 1'b0);
      wait_out(b + 29);
      t1_active = 1'b0;
      for (int k = 0; k < 29; k++) begin
         chk("ramp_data", got_d[b + k], (k < 28) ? 2 * k + 1 : 56);
         chk("ramp_last", got_l[b + k], (k == 28) ? 1 : 0);
      end

      // 2: signed compare
      b = got_d.size();
      push(-16'sd5, 1'b0);     push(-16'sd3, 1'b0);
      push(-16'sd32768, 1'b0); push(-16'sd1, 1'b0);
      push(16'sd7, 1'b0);      push(16'sd7, 1'b0);
      wait_out(b + 3);
      chk("neg_pair0", got_d[b], -3);
      chk("neg_pair1", got_d[b + 1], -1);
      chk("neg_pair2", got_d[b + 2], 7);

      // 3: downstream stall
      b = got_d.size();
      yr_mode = 2;
      push(16'sd10, 1'b0);
      push(16'sd20, 1'b0);
      x_data  = 16'sd30;
      x_valid = 1'b1;
      c = 0;
      while (!y_valid && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("stall_valid_rise", y_valid, 1);
      hd = y_data;
      hl = y_last;
      chk("stall_data_lit", hd, 20);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_x_ready", x_ready, 0);
         chk("stall_data", y_data, hd);
         chk("stall_last", y_last, hl);
      end
      yr_mode = 0;
      push(16'sd30, 1'b0);
      push(16'sd40, 1'b0);
      wait_out(b + 2);
      chk("resume0", got_d[b], 20);
      chk("resume1", got_d[b + 1], 40);

      // 5: reset mid-window
      push(16'sd900, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_reset_valid", y_valid, 0);
      chk("mid_reset_last", y_last, 0);
      @(posedge clk);
      #1;
      b = got_d.size();
      push(16'sd4, 1'b0);
      push(16'sd2, 1'b0);
      for (int i = 2; i < L; i++) push(sample_t'(i * 3 - 50), 1'b0);
      wait_out(b + 29);
      chk("post_reset_first", got_d[b], 4);
      seen900 = 1'b0;
      for (int k = 0; k < 29; k++) begin
         if (got_d[b + k] == 900) seen900 = 1'b1;
         chk("post_reset_last", got_l[b + k], (k == 28) ? 1 : 0);
      end
      chk("no_900", seen900, 0);

      // 6: two vectors with random gaps on both sides
      b = got_d.size();
      yr_mode = 1;
      for (int i = 0; i < 2 * L; i++) push(sample_t'($urandom), 1'b1);
      wait_out(b + 58);
      yr_mode = 0;
      for (int k = 0; k < 58; k++)
         chk("bb_last", got_l[b + k], (k == 28 || k == 57) ? 1 : 0);

      // 4: P=1 instance echoes every input with no bubbles
      v1[0] = 16'sd5;   v1[1] = -16'sd7;     v1[2] = 16'sd100;   v1[3] = 16'sd3;
      v1[4] = -16'sd1;  v1[5] = -16'sd32768; v1[6] = 16'sd32767; v1[7] = 16'sd0;
      x1_data  = v1[0];
      x1_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("p1_x_ready", x1_ready, 1);
         if (i > 0) begin
            chk("p1_valid", y1_valid, 1);
            chk("p1_data", y1_data, v1[i - 1]);
            chk("p1_last", y1_last, ((i - 1) % 4 == 3) ? 1 : 0);
         end
         @(posedge clk);
         #1;
         if (i < 7) x1_data = v1[i + 1];
      end
      x1_valid = 1'b0;
      @(negedge clk);
      chk("p1_final_data", y1_data, 0);
      chk("p1_final_valid", y1_valid, 1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
